// File: rtl/multiword_add_sequencer.sv
// Purpose : adds two WORDS x 16-bit operands by stepping one external 16-bit adder
//           over the slices, least-significant slice first, rippling the carry through a register.
// Latency : WORDS cycles from operand accept to o_out_valid.
//           Throughput is at best one operation per WORDS+2 cycles.
// Backpressure: the result is held in DONE until i_out_ready.
//           No new operands are taken until the result has been consumed.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_in_valid / o_in_ready    operand handshake (i_in_a, i_in_b, i_in_c)
//   o_out_valid / i_out_ready  result handshake (o_sum, o_c_out, o_ov)
//   o_adder_a/b/cin            slice operands and carry-in to the external adder
//   i_adder_s/cout             combinational sum and carry-out back from the adder
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [16*WORDS-1:0]   i_in_a,
  input  logic [16*WORDS-1:0]   i_in_b,
  input  logic                  i_in_c,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [16*WORDS-1:0]   o_sum,
  output logic                  o_c_out,
  output logic                  o_ov,
  output logic [15:0]           o_adder_a,
  output logic [15:0]           o_adder_b,
  output logic                  o_adder_cin,
  input  logic [15:0]           i_adder_s,
  input  logic                  i_adder_cout
);

  localparam int W     = 16*WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_cin;
  logic             r_carry;
  logic [W-1:0]     r_sum;
  logic             r_c_out;
  logic             r_ov;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_last;
  logic [15:0]      w_adder_a;
  logic [15:0]      w_adder_b;
  logic             w_adder_cin;

  assign w_last = (r_idx == IDX_W'(WORDS-1));

  // Adder operands are only live in RUN; elsewhere they are forced to zero
  // so the external adder sees a quiet input.
  always_comb begin
    w_adder_a   = 16'h0000;
    w_adder_b   = 16'h0000;
    w_adder_cin = 1'b0;
    if (r_state == S_RUN) begin
      w_adder_a   = r_a[16*r_idx +: 16];
      w_adder_b   = r_b[16*r_idx +: 16];
      // Slice 0 takes the operand carry-in; later slices take the rippled carry.
      w_adder_cin = (r_idx == '0) ? r_cin : r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ov        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_in_a;
            r_b        <= i_in_b;
            r_cin      <= i_in_c;
            r_idx      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum[16*r_idx +: 16] <= i_adder_s;
          r_carry               <= i_adder_cout;
          if (w_last) begin
            r_c_out     <= i_adder_cout;
            // Signed overflow: operands agree in sign but the top result bit differs.
            r_ov        <= (r_a[W-1] ~^ r_b[W-1]) & (i_adder_s[15] ^ r_a[W-1]);
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_c_out     = r_c_out;
  assign o_ov        = r_ov;
  assign o_adder_a   = w_adder_a;
  assign o_adder_b   = w_adder_b;
  assign o_adder_cin = w_adder_cin;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16*WORDS;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_c;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   sum;
  logic           c_out;
  logic           ov;
  logic [15:0]    adder_a;
  logic [15:0]    adder_b;
  logic           adder_cin;
  logic [15:0]    adder_s;
  logic           adder_cout;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the main sequence
  bit mon_prev_valid = 0;
  int mon_rise_cycle = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ov;
    int           t0;
  } exp_t;

  exp_t exp_q[$];

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_a       (in_a),
    .i_in_b       (in_b),
    .i_in_c       (in_c),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_sum        (sum),
    .o_c_out      (c_out),
    .o_ov         (ov),
    .o_adder_a    (adder_a),
    .o_adder_b    (adder_b),
    .o_adder_cin  (adder_cin),
    .i_adder_s    (adder_s),
    .i_adder_cout (adder_cout)
  );

  // External 16-bit adder: purely combinational.
  assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {16'h0000, adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: full-width unsigned sum for result/carry, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] u;
    logic signed [W:0] s;
    u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s = $signed({a[W-1], a}) + $signed({b[W-1], b}) + $signed({{W{1'b0}}, c});
    e.sum = u[W-1:0];
    e.c   = u[W];
    e.ov  = (s[W] != s[W-1]);
    e.t0  = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int k = 0; k < WORDS; k++) v[16*k +: 16] = rand_word();
    return v;
  endfunction

  // Presents one operand set and returns #1 after the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=in_ready_low want=in_ready_high");
    end else begin
      in_a = a;
      in_b = b;
      in_c = c;
      in_valid = 1'b1;
      e = model(a, b, c);
      e.t0 = cycle + 1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
    end
  endtask

  // out_ready generator, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares each result at the cycle its handshake is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_prev_valid = 0;
    end else begin
      if (in_ready && out_valid) begin
        checks++;
        errors++;
        $display("FAIL ready_valid_exclusive got=both_high want=not_both");
      end
      if (out_valid && !mon_prev_valid) mon_rise_cycle = cycle;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=%h want=no_result", sum);
        end else begin
          e = exp_q.pop_front();
          chk("sum", sum, e.sum);
          chk("c_out", W'(c_out), W'(e.c));
          chk("ov", W'(ov), W'(e.ov));
          chk("latency", W'(mon_rise_cycle - e.t0), W'(WORDS));
        end
      end
      mon_prev_valid = out_valid;
    end
  end

  initial begin
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic cin_exp [4];
    exp_t bx;
    int n;

    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_c = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum", sum, '0);
    chk("rst_c_out", W'(c_out), W'(0));
    chk("rst_ov", W'(ov), W'(0));
    chk("rst_adder_a", W'(adder_a), W'(0));

    // Carry crossing from slice 0 into slice 1; watch the slice carry-ins.
    rdy_mode = 0;
    cin_exp = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("adder_cin_%0d", k), W'(adder_cin), W'(cin_exp[k]));
    end
    wait_drain();

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);          // full wrap
    wait_drain();
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);          // signed overflow
    wait_drain();

    // Backpressure: result held, new operands offered but ignored.
    @(posedge clk);
    #1 rdy_mode = 2;
    out_ready = 1'b0;
    ta = 64'h1234_5678_9ABC_DEF0;
    tb = 64'hFEDC_BA98_7654_3210;
    bx = model(ta, tb, 1'b1);
    do_op(ta, tb, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_sum", sum, bx.sum);
      chk("bp_c_out", W'(c_out), W'(bx.c));
      chk("bp_in_ready", W'(in_ready), W'(0));
      in_a = 64'hAAAA_AAAA_AAAA_AAAA;
      in_b = 64'h5555_5555_5555_5555;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_capture", W'(out_valid), W'(0));
    end
    rdy_mode = 0;
    do_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    wait_drain();

    // Reset while the third slice is being driven.
    ta = 64'h4444_3333_2222_1111;
    do_op(ta, 64'h0000_0001_0000_0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrun_adder_a", W'(adder_a), W'(16'h3333));
    rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", W'(out_valid), W'(0));
    chk("midrun_sum", sum, '0);
    chk("midrun_adder_a_rst", W'(adder_a), W'(0));
    chk("midrun_in_ready", W'(in_ready), W'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(64'h1, 64'h1, 1'b0);
    wait_drain();

    // Randomized traffic with random result backpressure and idle gaps.
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
